// File: rtl/fetch_stage_pkg.sv
// ----------------------------------------------------------------------------
// fetch_stage_pkg
//   Shared definitions for the fetch stage and its neighbours:
//     - default PC / instruction widths
//     - fetch FSM state encoding (RUN / WAIT_MEM)
//     - IF/ID payload bundle layout {valid, pc, instr, pred_taken, pred_target},
//       which decode unpacks in the same order
// ----------------------------------------------------------------------------
package fetch_stage_pkg;

    localparam int PC_BITS_DEF    = 12;
    localparam int INSTR_BITS_DEF = 32;

    typedef enum logic {
        RUN      = 1'b0,
        WAIT_MEM = 1'b1
    } fetch_state_t;

    // IF/ID payload at the default widths; field order is the contract
    // between fetch and decode.
    typedef struct packed {
        logic                      valid;
        logic [PC_BITS_DEF-1:0]    pc;
        logic [INSTR_BITS_DEF-1:0] instr;
        logic                      pred_taken;
        logic [PC_BITS_DEF-1:0]    pred_target;
    } if_id_payload_t;

endpackage

// File: rtl/fetch_stage_if.sv
// ----------------------------------------------------------------------------
// fetch_stage_if
//   IF/ID pipeline-register bundle between fetch and decode.
//   master (fetch) : drives D_valid, D_pc, D_instr, D_pred_taken, D_pred_target;
//                    receives D_stall
//   slave (decode) : receives the D_* payload; drives D_stall
// ----------------------------------------------------------------------------
interface fetch_stage_if
    import fetch_stage_pkg::*;
#(
    parameter int PC_BITS    = PC_BITS_DEF,
    parameter int INSTR_BITS = INSTR_BITS_DEF
) ();

    logic                  D_valid;
    logic [PC_BITS-1:0]    D_pc;
    logic [INSTR_BITS-1:0] D_instr;
    logic                  D_pred_taken;
    logic [PC_BITS-1:0]    D_pred_target;
    logic                  D_stall;

    modport master (
        output D_valid, D_pc, D_instr, D_pred_taken, D_pred_target,
        input  D_stall
    );

    modport slave (
        input  D_valid, D_pc, D_instr, D_pred_taken, D_pred_target,
        output D_stall
    );

endinterface

// File: rtl/fetch_stage_branch_resolve.sv
// ----------------------------------------------------------------------------
// branch_resolve
//   Combinational branch check for the instruction in EX.
//   en            : a branch is being resolved this cycle (EX_brn & !MEM_stall)
//   ex_pc         : PC of the branch
//   alu_out       : resolved target
//   true_taken    : resolved direction
//   pred_taken    : predicted direction carried with the branch
//   pred_target   : predicted target carried with the branch
//   mispredict    : resolution disagrees with prediction (gated by en)
//   redirect      : correct next PC after the branch
// ----------------------------------------------------------------------------
module branch_resolve
    import fetch_stage_pkg::*;
#(
    parameter int PC_BITS = PC_BITS_DEF
) (
    input  logic               en,
    input  logic [PC_BITS-1:0] ex_pc,
    input  logic [PC_BITS-1:0] alu_out,
    input  logic               true_taken,
    input  logic               pred_taken,
    input  logic [PC_BITS-1:0] pred_target,
    output logic               mispredict,
    output logic [PC_BITS-1:0] redirect
);

    logic dir_wrong;
    logic target_wrong;

    assign dir_wrong    = (true_taken != pred_taken);
    // A wrong target only matters when the branch was actually taken.
    assign target_wrong = true_taken & (alu_out != pred_target);
    assign mispredict   = en & (dir_wrong | target_wrong);
    assign redirect     = true_taken ? alu_out : ex_pc + PC_BITS'(1);

endmodule

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   IF stage: owns the PC, consumes the branch-buffer prediction, loads the
//   IF/ID register from instruction memory and redirects on EX mispredicts.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   F_pc                : fetch PC (branch-buffer lookup + imem address)
//   F_BP_taken/_target  : prediction for F_pc
//   imem_rdata/_valid   : instruction at F_pc and its valid
//   MEM_stall           : back-end freeze (also freezes EX resolution)
//   EX_*                : branch in EX and its prediction
//   if_id               : IF/ID payload out, D_stall in
//   EX_flush            : combinational kill of ID/EX on mispredict
//   fetch_state         : 0 = RUN, 1 = WAIT_MEM
//   branch_cnt          : saturating count of resolved branches
//   mispredict_cnt      : saturating count of mispredicts
// ----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int          PC_BITS    = PC_BITS_DEF,
    parameter int          INSTR_BITS = INSTR_BITS_DEF,
    parameter int unsigned RESET_PC   = 0,
    parameter int          CNT_BITS   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [PC_BITS-1:0]    F_pc,
    input  logic                  F_BP_taken,
    input  logic [PC_BITS-1:0]    F_BP_target_pc,
    input  logic [INSTR_BITS-1:0] imem_rdata,
    input  logic                  imem_valid,
    input  logic                  MEM_stall,
    input  logic                  EX_brn,
    input  logic [PC_BITS-1:0]    EX_pc,
    input  logic [PC_BITS-1:0]    EX_alu_out,
    input  logic                  EX_true_taken,
    input  logic                  EX_pred_taken,
    input  logic [PC_BITS-1:0]    EX_pred_target,
    fetch_stage_if.master         if_id,
    output logic                  EX_flush,
    output logic                  fetch_state,
    output logic [CNT_BITS-1:0]   branch_cnt,
    output logic [CNT_BITS-1:0]   mispredict_cnt
);

    logic [PC_BITS-1:0]    pc_reg, pc_next;
    logic                  d_valid_reg, d_valid_next;
    logic [PC_BITS-1:0]    d_pc_reg, d_pc_next;
    logic [INSTR_BITS-1:0] d_instr_reg, d_instr_next;
    logic                  d_pred_taken_reg, d_pred_taken_next;
    logic [PC_BITS-1:0]    d_pred_target_reg, d_pred_target_next;
    fetch_state_t          state_reg, state_next;
    logic [CNT_BITS-1:0]   branch_cnt_reg, mispredict_cnt_reg;

    logic                  resolve;
    logic                  mispredict;
    logic [PC_BITS-1:0]    redirect;
    logic [PC_BITS-1:0]    pred_next;
    logic                  stall;

    // While the back end is frozen the EX branch is not resolved at all:
    // no redirect, no flush, no counting until MEM_stall drops.
    assign resolve = EX_brn & ~MEM_stall;
    assign stall   = if_id.D_stall | MEM_stall;

    branch_resolve #(
        .PC_BITS (PC_BITS)
    ) u_branch_resolve (
        .en          (resolve),
        .ex_pc       (EX_pc),
        .alu_out     (EX_alu_out),
        .true_taken  (EX_true_taken),
        .pred_taken  (EX_pred_taken),
        .pred_target (EX_pred_target),
        .mispredict  (mispredict),
        .redirect    (redirect)
    );

    assign pred_next = F_BP_taken ? F_BP_target_pc : pc_reg + PC_BITS'(1);

    // Next-state / next-PC selection in priority order:
    // mispredict > stall > imem miss > normal fetch.
    always_comb begin
        pc_next            = pc_reg;
        d_valid_next       = d_valid_reg;
        d_pc_next          = d_pc_reg;
        d_instr_next       = d_instr_reg;
        d_pred_taken_next  = d_pred_taken_reg;
        d_pred_target_next = d_pred_target_reg;
        state_next         = state_reg;

        if (mispredict) begin
            pc_next      = redirect;
            d_valid_next = 1'b0;
            state_next   = RUN;
        end else if (stall) begin
            // everything holds
        end else if (!imem_valid) begin
            d_valid_next = 1'b0;
            state_next   = WAIT_MEM;
        end else begin
            d_valid_next       = 1'b1;
            d_pc_next          = pc_reg;
            d_instr_next       = imem_rdata;
            d_pred_taken_next  = F_BP_taken;
            d_pred_target_next = pred_next;
            pc_next            = pred_next;
            state_next         = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg             <= PC_BITS'(RESET_PC);
            d_valid_reg        <= 1'b0;
            d_pc_reg           <= '0;
            d_instr_reg        <= '0;
            d_pred_taken_reg   <= 1'b0;
            d_pred_target_reg  <= '0;
            state_reg          <= RUN;
            branch_cnt_reg     <= '0;
            mispredict_cnt_reg <= '0;
        end else begin
            pc_reg             <= pc_next;
            d_valid_reg        <= d_valid_next;
            d_pc_reg           <= d_pc_next;
            d_instr_reg        <= d_instr_next;
            d_pred_taken_reg   <= d_pred_taken_next;
            d_pred_target_reg  <= d_pred_target_next;
            state_reg          <= state_next;
            // Statistics saturate at all-ones instead of wrapping.
            if (resolve && (branch_cnt_reg != '1)) begin
                branch_cnt_reg <= branch_cnt_reg + CNT_BITS'(1);
            end
            if (mispredict && (mispredict_cnt_reg != '1)) begin
                mispredict_cnt_reg <= mispredict_cnt_reg + CNT_BITS'(1);
            end
        end
    end

    assign F_pc                = pc_reg;
    assign if_id.D_valid       = d_valid_reg;
    assign if_id.D_pc          = d_pc_reg;
    assign if_id.D_instr       = d_instr_reg;
    assign if_id.D_pred_taken  = d_pred_taken_reg;
    assign if_id.D_pred_target = d_pred_target_reg;
    assign EX_flush            = mispredict;
    assign fetch_state         = state_reg;
    assign branch_cnt          = branch_cnt_reg;
    assign mispredict_cnt      = mispredict_cnt_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage. A cycle-level reference model of the
//   fetch rules runs alongside the DUT; directed scenarios plus a randomized
//   stretch compare the DUT against it. Counters use a narrow width so that
//   saturation is reachable quickly.
// ----------------------------------------------------------------------------
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam int PCB  = 12;
    localparam int IB   = 32;
    localparam int CB   = 10;
    localparam int CMAX = (1 << CB) - 1;
    localparam int VW   = PCB + 1 + PCB + IB + 1 + PCB + 1 + CB + CB;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [PCB-1:0]  f_pc;
    logic            bp_taken;
    logic [PCB-1:0]  bp_target;
    logic [IB-1:0]   imem_rdata;
    logic            imem_valid;
    logic            mem_stall;
    logic            ex_brn;
    logic [PCB-1:0]  ex_pc;
    logic [PCB-1:0]  ex_alu;
    logic            ex_true;
    logic            ex_pt;
    logic [PCB-1:0]  ex_ptgt;
    logic            ex_flush;
    logic            fetch_state;
    logic [CB-1:0]   branch_cnt;
    logic [CB-1:0]   mispredict_cnt;

    fetch_stage_if #(.PC_BITS(PCB), .INSTR_BITS(IB)) if_id ();

    always #5 clk = ~clk;

    fetch_stage #(
        .PC_BITS    (PCB),
        .INSTR_BITS (IB),
        .RESET_PC   (0),
        .CNT_BITS   (CB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .F_pc           (f_pc),
        .F_BP_taken     (bp_taken),
        .F_BP_target_pc (bp_target),
        .imem_rdata     (imem_rdata),
        .imem_valid     (imem_valid),
        .MEM_stall      (mem_stall),
        .EX_brn         (ex_brn),
        .EX_pc          (ex_pc),
        .EX_alu_out     (ex_alu),
        .EX_true_taken  (ex_true),
        .EX_pred_taken  (ex_pt),
        .EX_pred_target (ex_ptgt),
        .if_id          (if_id),
        .EX_flush       (ex_flush),
        .fetch_state    (fetch_state),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    // Reference model state
    logic [PCB-1:0] m_pc, m_dpc, m_dptgt;
    logic           m_dv, m_dpt, m_wait;
    logic [IB-1:0]  m_dinstr;
    int             m_bc, m_mc;

    int tests = 0;
    int fails = 0;

    function automatic logic [VW-1:0] dut_vec();
        return {f_pc, if_id.D_valid, if_id.D_pc, if_id.D_instr, if_id.D_pred_taken,
                if_id.D_pred_target, fetch_state, branch_cnt, mispredict_cnt};
    endfunction

    function automatic logic [VW-1:0] model_vec();
        return {m_pc, m_dv, m_dpc, m_dinstr, m_dpt, m_dptgt, m_wait, CB'(m_bc), CB'(m_mc)};
    endfunction

    function automatic logic exp_flush();
        return ex_brn && !mem_stall &&
               ((ex_true != ex_pt) || (ex_true && (ex_alu != ex_ptgt)));
    endfunction

    task automatic model_reset();
        m_pc = '0; m_dv = 0; m_dpc = '0; m_dinstr = '0; m_dpt = 0; m_dptgt = '0;
        m_wait = 0; m_bc = 0; m_mc = 0;
    endtask

    task automatic idle_inputs();
        bp_taken = 0; bp_target = '0; imem_rdata = $urandom; imem_valid = 1;
        if_id.D_stall = 0; mem_stall = 0; ex_brn = 0; ex_pc = '0; ex_alu = '0;
        ex_true = 0; ex_pt = 0; ex_ptgt = '0;
    endtask

    // Advance one clock: apply the fetch rules to the model, then land 1 time
    // unit after the rising edge where the DUT outputs are stable.
    task automatic tick();
        logic           mis;
        logic [PCB-1:0] pnext;
        logic [PCB-1:0] n_pc, n_dpc, n_dptgt;
        logic           n_dv, n_dpt, n_wait;
        logic [IB-1:0]  n_dinstr;
        int             n_bc, n_mc;
        mis = exp_flush();
        pnext = bp_taken ? bp_target : m_pc + 12'd1;
        n_pc = m_pc; n_dpc = m_dpc; n_dptgt = m_dptgt; n_dv = m_dv; n_dpt = m_dpt;
        n_wait = m_wait; n_dinstr = m_dinstr; n_bc = m_bc; n_mc = m_mc;
        if (ex_brn && !mem_stall) n_bc = (m_bc >= CMAX) ? CMAX : m_bc + 1;
        if (mis) n_mc = (m_mc >= CMAX) ? CMAX : m_mc + 1;
        if (mis) begin
            n_pc = ex_true ? ex_alu : ex_pc + 12'd1;
            n_dv = 0; n_wait = 0;
        end else if (if_id.D_stall || mem_stall) begin
            n_pc = m_pc;
        end else if (!imem_valid) begin
            n_dv = 0; n_wait = 1;
        end else begin
            n_dv = 1; n_dpc = m_pc; n_dinstr = imem_rdata; n_dpt = bp_taken;
            n_dptgt = pnext; n_pc = pnext; n_wait = 0;
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_dpc = n_dpc; m_dptgt = n_dptgt; m_dv = n_dv; m_dpt = n_dpt;
        m_wait = n_wait; m_dinstr = n_dinstr; m_bc = n_bc; m_mc = n_mc;
    endtask

    task automatic test_reset();
        idle_inputs();
        ex_true = 1; ex_pt = 0;   // would mispredict if EX_brn were set
        model_reset();
        #1;
        tests++;
        if (dut_vec() !== model_vec()) begin
            fails++; $display("FAIL reset_state: got %h expected %h", dut_vec(), model_vec());
        end
        tests++;
        if (ex_flush !== 1'b0) begin
            fails++; $display("FAIL reset_flush_no_brn: got %b expected 0", ex_flush);
        end
        @(posedge clk); #1;
        rst_n = 1;
        idle_inputs();
        $display("[TB] test_reset done");
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 5; i++) begin
            imem_rdata = $urandom;
            #1;
            tests++;
            if (f_pc !== PCB'(i)) begin
                fails++; $display("FAIL seq_fpc: got %h expected %h", f_pc, PCB'(i));
            end
            tests++;
            if (i == 0 && if_id.D_valid !== 1'b0) begin
                fails++; $display("FAIL seq_dvalid0: got %b expected 0", if_id.D_valid);
            end else if (i > 0 && (if_id.D_valid !== 1'b1 || if_id.D_pc !== PCB'(i - 1))) begin
                fails++; $display("FAIL seq_dpc: got v=%b pc=%h expected v=1 pc=%h",
                                  if_id.D_valid, if_id.D_pc, PCB'(i - 1));
            end
            tick();
            tests++;
            if (dut_vec() !== model_vec()) begin
                fails++; $display("FAIL seq_model: got %h expected %h", dut_vec(), model_vec());
            end
        end
        $display("[TB] test_sequential done");
    endtask

    task automatic test_prediction();
        idle_inputs();
        bp_taken = 1; bp_target = 12'h010;
        tick();
        bp_taken = 1; bp_target = 12'h040; imem_rdata = $urandom;
        #1;
        tests++;
        if (f_pc !== 12'h010) begin
            fails++; $display("FAIL pred_fpc_before: got %h expected 010", f_pc);
        end
        tick();
        tests++;
        if (f_pc !== 12'h040 || if_id.D_pred_taken !== 1'b1 ||
            if_id.D_pred_target !== 12'h040 || if_id.D_pc !== 12'h010) begin
            fails++; $display("FAIL pred_follow: got pc=%h pt=%b tgt=%h dpc=%h expected 040 1 040 010",
                              f_pc, if_id.D_pred_taken, if_id.D_pred_target, if_id.D_pc);
        end
        idle_inputs();
        $display("[TB] test_prediction done");
    endtask

    task automatic test_mispredict();
        idle_inputs();
        ex_brn = 1; ex_pc = 12'h020; ex_true = 1; ex_alu = 12'h080; ex_pt = 0; ex_ptgt = 12'h000;
        #1;
        tests++;
        if (ex_flush !== 1'b1) begin
            fails++; $display("FAIL mis_flush: got %b expected 1", ex_flush);
        end
        tick();
        ex_brn = 0; imem_rdata = $urandom;
        tests++;
        if (f_pc !== 12'h080 || if_id.D_valid !== 1'b0 || branch_cnt !== CB'(1) ||
            mispredict_cnt !== CB'(1)) begin
            fails++; $display("FAIL mis_redirect: got pc=%h dv=%b bc=%0d mc=%0d expected 080 0 1 1",
                              f_pc, if_id.D_valid, branch_cnt, mispredict_cnt);
        end
        tick();
        tests++;
        if (if_id.D_valid !== 1'b1 || if_id.D_pc !== 12'h080) begin
            fails++; $display("FAIL mis_bubble: got dv=%b dpc=%h expected 1 080",
                              if_id.D_valid, if_id.D_pc);
        end
        $display("[TB] test_mispredict done");
    endtask

    task automatic test_mem_stall_mispredict();
        logic [PCB-1:0] held;
        idle_inputs();
        held = f_pc;
        ex_brn = 1; ex_pc = 12'h030; ex_true = 1; ex_alu = 12'h0A0; ex_pt = 0; ex_ptgt = 12'h000;
        mem_stall = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests++;
            if (ex_flush !== 1'b0) begin
                fails++; $display("FAIL mstall_flush: got %b expected 0", ex_flush);
            end
            tick();
            tests++;
            if (f_pc !== held || branch_cnt !== CB'(1) || mispredict_cnt !== CB'(1)) begin
                fails++; $display("FAIL mstall_hold: got pc=%h bc=%0d mc=%0d expected %h 1 1",
                                  f_pc, branch_cnt, mispredict_cnt, held);
            end
        end
        mem_stall = 0;
        #1;
        tests++;
        if (ex_flush !== 1'b1) begin
            fails++; $display("FAIL mstall_release_flush: got %b expected 1", ex_flush);
        end
        tick();
        tests++;
        if (f_pc !== 12'h0A0 || branch_cnt !== CB'(2) || mispredict_cnt !== CB'(2)) begin
            fails++; $display("FAIL mstall_redirect: got pc=%h bc=%0d mc=%0d expected 0a0 2 2",
                              f_pc, branch_cnt, mispredict_cnt);
        end
        idle_inputs();
        $display("[TB] test_mem_stall_mispredict done");
    endtask

    task automatic test_wait_mem();
        logic [PCB-1:0] held;
        logic [IB-1:0]  word;
        idle_inputs();
        tick();
        held = f_pc;
        imem_valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (fetch_state !== 1'b1 || if_id.D_valid !== 1'b0 || f_pc !== held) begin
                fails++; $display("FAIL wait_hold: got st=%b dv=%b pc=%h expected 1 0 %h",
                                  fetch_state, if_id.D_valid, f_pc, held);
            end
        end
        imem_valid = 1; word = $urandom; imem_rdata = word;
        tick();
        tests++;
        if (fetch_state !== 1'b0 || if_id.D_valid !== 1'b1 || if_id.D_instr !== word ||
            if_id.D_pc !== held) begin
            fails++; $display("FAIL wait_capture: got st=%b dv=%b instr=%h dpc=%h expected 0 1 %h %h",
                              fetch_state, if_id.D_valid, if_id.D_instr, if_id.D_pc, word, held);
        end
        if_id.D_stall = 1;
        for (int i = 0; i < 2; i++) begin
            imem_rdata = $urandom;
            tick();
            tests++;
            if (dut_vec() !== model_vec() || if_id.D_instr !== word || f_pc !== held + 12'd1) begin
                fails++; $display("FAIL dstall_hold: got %h expected %h", dut_vec(), model_vec());
            end
        end
        idle_inputs();
        $display("[TB] test_wait_mem done");
    endtask

    task automatic test_wrap();
        idle_inputs();
        bp_taken = 1; bp_target = 12'hFFF;
        tick();
        bp_taken = 0;
        #1;
        tests++;
        if (f_pc !== 12'hFFF) begin
            fails++; $display("FAIL wrap_setup: got %h expected fff", f_pc);
        end
        tick();
        tests++;
        if (f_pc !== 12'h000 || if_id.D_pred_target !== 12'h000) begin
            fails++; $display("FAIL wrap_pc: got pc=%h tgt=%h expected 000 000",
                              f_pc, if_id.D_pred_target);
        end
        $display("[TB] test_wrap done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bp_taken = ($urandom_range(0, 3) == 0);
            bp_target = PCB'($urandom);
            imem_rdata = $urandom;
            imem_valid = ($urandom_range(0, 4) != 0);
            if_id.D_stall = ($urandom_range(0, 5) == 0);
            mem_stall = ($urandom_range(0, 5) == 0);
            ex_brn = ($urandom_range(0, 2) == 0);
            ex_pc = PCB'($urandom);
            ex_alu = PCB'($urandom);
            ex_true = $urandom_range(0, 1);
            ex_pt = ($urandom_range(0, 3) == 0) ? ~ex_true : ex_true;
            ex_ptgt = ($urandom_range(0, 1) == 0) ? ex_alu : PCB'($urandom);
            #1;
            tests++;
            if (ex_flush !== exp_flush()) begin
                fails++; $display("FAIL rand_flush[%0d]: got %b expected %b", i, ex_flush, exp_flush());
            end
            tick();
            tests++;
            if (dut_vec() !== model_vec()) begin
                fails++; $display("FAIL rand_state[%0d]: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
        idle_inputs();
        $display("[TB] test_random done");
    endtask

    task automatic test_saturation();
        idle_inputs();
        ex_brn = 1; ex_true = 0; ex_pt = 0;
        for (int i = 0; i < CMAX + 10; i++) begin
            imem_valid = $urandom_range(0, 1);
            tick();
        end
        tests++;
        if (branch_cnt !== CB'(CMAX) || dut_vec() !== model_vec()) begin
            fails++; $display("FAIL sat_branch: got bc=%0d expected %0d", branch_cnt, CMAX);
        end
        ex_true = 1; ex_pt = 1;
        for (int i = 0; i < CMAX + 10; i++) begin
            ex_alu = PCB'($urandom);
            ex_ptgt = ex_alu + 12'd1;
            tick();
        end
        tests++;
        if (mispredict_cnt !== CB'(CMAX) || branch_cnt !== CB'(CMAX) ||
            dut_vec() !== model_vec()) begin
            fails++; $display("FAIL sat_mispredict: got bc=%0d mc=%0d expected %0d %0d",
                              branch_cnt, mispredict_cnt, CMAX, CMAX);
        end
        idle_inputs();
        $display("[TB] test_saturation done");
    endtask

    task automatic test_async_reset();
        idle_inputs();
        imem_valid = 0;
        tick();
        tick();
        if_id.D_stall = 1;
        #2;
        rst_n = 0;
        model_reset();
        #1;
        tests++;
        if (dut_vec() !== model_vec() || ex_flush !== 1'b0) begin
            fails++; $display("FAIL async_reset: got %h expected %h", dut_vec(), model_vec());
        end
        @(posedge clk); #1;
        rst_n = 1;
        idle_inputs();
        tick();
        tests++;
        if (f_pc !== 12'h001 || if_id.D_valid !== 1'b1 || if_id.D_pc !== 12'h000) begin
            fails++; $display("FAIL async_restart: got pc=%h dv=%b dpc=%h expected 001 1 000",
                              f_pc, if_id.D_valid, if_id.D_pc);
        end
        $display("[TB] test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_prediction();
        test_mispredict();
        test_mem_stall_mispredict();
        test_wait_mem();
        test_wrap();
        test_random();
        test_saturation();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage that owns the PC register and drives the fetch-time lookup of the branch buffer. Consumes its predicted next PC, fetches from instruction memory and loads the IF/ID pipeline register.
- Detects branch mispredictions resolved in EX and redirects the PC. Flushes wrong-path work and keeps saturating branch/mispredict statistics counters.

Parameters:
PC_BITS, 12, PC / address width (word-addressed; sequential PC = pc+1)
INSTR_BITS, 32, instruction width
RESET_PC, 0, PC loaded on reset
CNT_BITS, 16, width of statistics counters

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
F_pc  out  PC_BITS  current fetch PC (to branch buffer lookup and imem address)
F_BP_taken  in  1  branch buffer prediction for F_pc
F_BP_target_pc  in  PC_BITS  branch buffer predicted target (used only when F_BP_taken=1)
imem_rdata  in  INSTR_BITS  instruction at F_pc
imem_valid  in  1  imem_rdata valid this cycle
D_stall  in  1  decode cannot accept
MEM_stall  in  1  back-end freeze (EX frozen too)
EX_brn  in  1  EX holds a branch
EX_pc  in  PC_BITS  PC of EX branch
EX_alu_out  in  PC_BITS  resolved target
EX_true_taken  in  1  resolved direction
EX_pred_taken  in  1  prediction carried with the branch
EX_pred_target  in  PC_BITS  predicted target carried with the branch
D_valid  out  1  IF/ID register holds a real instruction
D_pc  out  PC_BITS  its PC
D_instr  out  INSTR_BITS  its instruction
D_pred_taken  out  1  prediction for it
D_pred_target  out  PC_BITS  predicted next PC for it
EX_flush  out  1  combinational; kill the instruction in ID/EX this cycle
fetch_state  out  1  0=RUN, 1=WAIT_MEM
branch_cnt  out  CNT_BITS  resolved branches, saturating
mispredict_cnt  out  CNT_BITS  mispredictions, saturating

Behaviour:
- Reset (rst_n=0, async): pc=RESET_PC, D_valid=0, D_pc=0, D_instr=0, D_pred_taken=0, D_pred_target=0, state=RUN, both counters=0. EX_flush=0 whenever EX_brn=0.
- F_pc = pc. pred_next = F_BP_taken ? F_BP_target_pc : pc+1. All PC adds wrap mod 2^PC_BITS, e.g. 0xFFF+1 = 0x000.
- Branch resolution, only when EX_brn & !MEM_stall:
  - mispredict = (EX_true_taken != EX_pred_taken) | (EX_true_taken & (EX_alu_out != EX_pred_target)).
  - redirect = EX_true_taken ? EX_alu_out : EX_pc+1.
- Priority per cycle:
  1. mispredict: pc<=redirect; D_valid<=0; EX_flush=1; state<=RUN. Overrides D_stall and imem_valid.
  2. stall (D_stall|MEM_stall): pc, IF/ID register and state hold.
  3. !imem_valid: D_valid<=0; pc holds; state<=WAIT_MEM.
  4. imem_valid: D <= {1, pc, imem_rdata, F_BP_taken, pred_next}; pc<=pred_next; state<=RUN.
- Latency: instruction returned at cycle n appears on D_* at n+1. After a mispredict there is exactly 1 bubble cycle before the redirected instruction, assuming imem_valid=1.
- Counters, updated in resolution cycles: branch_cnt+1 per resolution; mispredict_cnt+1 per mispredict. Both saturate at all-ones, with no wrap.
- WAIT_MEM has no timeout. It leaves on imem_valid or on a mispredict.
- Reset asserted mid-stall or mid-wait: immediate return to reset values.

Decomposition:
- Shared package:
  - PC_BITS and INSTR_BITS defaults.
  - RUN/WAIT_MEM state encoding.
  - IF/ID payload bundle ordering {valid, pc, instr, pred_taken, pred_target}, reused by decode.
- One sub-module: branch_resolve. It is combinational and computes mispredict and redirect from the EX_* inputs; decode/EX testbenches reuse it.
- Counters stay inline.

Test Plan:
- Reset release, imem_valid=1, no prediction hits, RESET_PC=0 -> F_pc 0,1,2,3 on successive cycles; D_pc lags by one; D_valid=1 from the second cycle.
- F_pc=0x010, F_BP_taken=1, F_BP_target_pc=0x040 -> next F_pc=0x040; D_pred_taken=1; D_pred_target=0x040.
- EX_brn=1, EX_pc=0x020, EX_true_taken=1, EX_alu_out=0x080, EX_pred_taken=0 -> EX_flush=1 that cycle; next F_pc=0x080; D_valid=0 for one cycle; mispredict_cnt=1, branch_cnt=1.
- Same mispredict with MEM_stall=1 -> no redirect, no flush, counters unchanged; the redirect happens in the first cycle after MEM_stall drops.
- imem_valid=0 for 3 cycles -> fetch_state=1, D_valid=0, F_pc held. On return of imem_valid, the instruction is captured and state=RUN. D_stall=1 with imem_valid=1 -> D_* and F_pc held.
- pc=0xFFF with no prediction -> next pc=0x000. Set branch_cnt to all-ones via forced 65536 correct branches -> stays at 0xFFFF. Assert rst_n low mid-stream -> all outputs at reset values immediately.
